controle_contexto: RTL

CONTROLE_CONTEXTO -- requirements
Module: controle_contexto

---
 rtl/controle_contexto_pkg.sv | 22 ++
 rtl/controle_contexto_contador_quantum.sv | 40 ++++
 rtl/controle_contexto.sv | 119 +++++++++++
 3 files changed

// File: rtl/controle_contexto_pkg.sv
// Shared definitions for the context-switch controller: FSM encodings,
// troca_contexto codes seen by the CPU and the reset quantum.
package controle_contexto_pkg;

  localparam int QUANTUM_W = 16;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    CONTANDO = 2'b01,
    KERNEL   = 2'b10,
    TROCA    = 2'b11
  } estado_t;

  // Codes driven on troca_contexto; the CPU compares against TC_TROCA.
  localparam logic [1:0] TC_OCIOSO   = 2'b00;
  localparam logic [1:0] TC_CONTANDO = 2'b01;
  localparam logic [1:0] TC_KERNEL   = 2'b10;
  localparam logic [1:0] TC_TROCA    = 2'b11;

  localparam logic [QUANTUM_W-1:0] QUANTUM_PADRAO_DEF = 16'd100;

endpackage

// File: rtl/controle_contexto_contador_quantum.sv
// Loadable 16-bit quantum down-counter with hold and zero flag.
// Clear wins over load, load wins over decrement; it never wraps below zero.
module contador_quantum
  import controle_contexto_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 load_i,
  input  logic [QUANTUM_W-1:0] load_val_i,
  input  logic                 dec_i,
  output logic [QUANTUM_W-1:0] count_o,
  output logic                 zero_o
);

  logic [QUANTUM_W-1:0] cnt_q, cnt_d;

  assign zero_o  = (cnt_q == '0);
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      cnt_d = cnt_q - {{(QUANTUM_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/controle_contexto.sv
// Quantum-based preemption controller: counts down the running process's
// quantum, requests a context switch on expiry and waits for the scheduler.
module controle_contexto
  import controle_contexto_pkg::*;
#(
  parameter logic [QUANTUM_W-1:0] QUANTUM_PADRAO = QUANTUM_PADRAO_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 halt,
  input  logic                 quantum_load,
  input  logic [QUANTUM_W-1:0] quantum_value,
  input  logic                 retorno,
  input  logic [31:0]          pc,
  output logic [1:0]           troca_contexto,
  output logic [31:0]          pc_salvo,
  output logic [QUANTUM_W-1:0] restante,
  output logic [7:0]           num_trocas
);

  estado_t              estado_q, estado_d;
  logic [QUANTUM_W-1:0] quantum_q, quantum_d;
  logic [31:0]          pc_salvo_q, pc_salvo_d;
  logic [7:0]           num_trocas_q, num_trocas_d;

  logic                 cnt_clear, cnt_load, cnt_dec, cnt_zero;
  logic [QUANTUM_W-1:0] cnt_val;
  logic                 quantum_zero;

  assign quantum_zero = (quantum_q == '0);

  contador_quantum u_contador (
    .clk_i      (clock),
    .rst_ni     (reset),
    .clear_i    (cnt_clear),
    .load_i     (cnt_load),
    .load_val_i (quantum_q),
    .dec_i      (cnt_dec),
    .count_o    (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    estado_d     = estado_q;
    quantum_d    = quantum_load ? quantum_value : quantum_q;
    pc_salvo_d   = pc_salvo_q;
    num_trocas_d = num_trocas_q;
    cnt_clear    = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;

    case (estado_q)
      OCIOSO: begin
        if (enable && !quantum_zero) begin
          estado_d = CONTANDO;
          cnt_load = 1'b1;
        end else begin
          cnt_clear = 1'b1;
        end
      end
      CONTANDO: begin
        // Disable and a zeroed quantum both abort the countdown before expiry.
        if (!enable || quantum_zero || cnt_zero) begin
          estado_d  = OCIOSO;
          cnt_clear = 1'b1;
        end else if (!halt) begin
          cnt_dec = 1'b1;
          if (cnt_val == {{(QUANTUM_W-1){1'b0}}, 1'b1}) begin
            estado_d   = TROCA;
            pc_salvo_d = pc;
          end
        end
      end
      TROCA: begin
        estado_d     = KERNEL;
        num_trocas_d = num_trocas_q + 8'd1;
      end
      KERNEL: begin
        if (!enable) begin
          estado_d  = OCIOSO;
          cnt_clear = 1'b1;
        end else if (retorno) begin
          if (quantum_zero) begin
            estado_d  = OCIOSO;
            cnt_clear = 1'b1;
          end else begin
            estado_d = CONTANDO;
            cnt_load = 1'b1;
          end
        end
      end
      default: begin
        estado_d  = OCIOSO;
        cnt_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q     <= OCIOSO;
      quantum_q    <= QUANTUM_PADRAO;
      pc_salvo_q   <= '0;
      num_trocas_q <= '0;
    end else begin
      estado_q     <= estado_d;
      quantum_q    <= quantum_d;
      pc_salvo_q   <= pc_salvo_d;
      num_trocas_q <= num_trocas_d;
    end
  end

  assign troca_contexto = estado_q;
  assign pc_salvo       = pc_salvo_q;
  assign restante       = cnt_val;
  assign num_trocas     = num_trocas_q;

endmodule
